layer2_classifier: RTL
======================

LAYER2_CLASSIFIER -- requirements
Module: layer2_classifier

Interface
REQ-001 SHALL have parameter N_HID, default 32, meaning hidden-layer width; index N_HID is the bias row.
REQ-002 SHALL have parameter FRAC, default 16, meaning fraction bits of the signed Q(32-FRAC).FRAC format used by weights, activations and scores.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-006 SHALL have port ctr2, output, 32, layer-2 weight-memory row address.
REQ-007 SHALL have ports w2_0..w2_9, input, 32 each, layer-2 weight/bias for output neuron k, valid one cycle after ctr2 is presented.
REQ-008 SHALL have port h_addr, output, 5, hidden-activation buffer address.
REQ-009 SHALL have port h_data, input, 32, hidden activation, valid one cycle after h_addr is presented.
REQ-010 SHALL have port busy, output, 1, high from the start-accept edge until the done cycle ends.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port digit, output, 4, classified digit 0..9.
REQ-013 SHALL have port max_score, output, 32, signed winning score.

Function
REQ-014 SHALL use FSM states IDLE, FETCH, DRAIN, ARGMAX; IDLE->FETCH on start at edge E0; start is ignored outside IDLE.
REQ-015 SHALL clear all ten accumulators to 0 at E0.
REQ-016 SHALL present ctr2 = k and h_addr = k[4:0] during the cycle after edge Ek, for k = 0..N_HID; ctr2 SHALL be 0 in IDLE.
REQ-017 SHALL enter DRAIN after ctr2 = N_HID has been presented; DRAIN SHALL last until the last accumulate edge.
REQ-018 SHALL carry a delayed index/valid alongside the 1-cycle memory latency, so that row k is accumulated at edge E(k+2), with the last accumulate at E(N_HID+2) = E34.
REQ-019 SHALL compute acc_j += (w2_j * a) >>> FRAC for rows k < N_HID, where a = h_data, the product is a signed 64-bit value, the shift is arithmetic, and the 32-bit sum wraps in two's complement with no saturation.
REQ-020 SHALL, for the bias row k = N_HID, ignore h_data and use a = 1.0 (1 << FRAC), so that acc_j += w2_j.
REQ-021 SHALL scan the accumulators in ARGMAX, one neuron per edge: load neuron 0 at E35, then compare neurons 1..9 at E36..E44.
REQ-022 SHALL use signed compares; a candidate replaces the best only if strictly greater, so on ties the lowest index wins.
REQ-023 SHALL, at E44, update digit and max_score with the final result, pulse done high for exactly the cycle E44-E45, drop busy, and return to IDLE.
REQ-024 SHALL hold digit and max_score stable from E44 until the next run's E44; they SHALL NOT change mid-run.
REQ-025 SHALL accept a start presented in the cycle after E44, i.e. at edge E45.
REQ-026 SHALL give a total latency of start-accept edge to done-high of 44 clock cycles for N_HID = 32.

Reset
REQ-027 SHALL, on resetn low at any time, asynchronously force: state IDLE, ctr2 = 0, h_addr = 0, busy = 0, done = 0, digit = 0, max_score = 0, accumulators = 0.
REQ-028 SHALL abort a run in progress on reset mid-operation; no done is produced for it, and the first start after resetn rises begins a fresh run.

Verification
REQ-029 All weights 0, w2_3 bias row = 0x00050000, all h_data = 0x00010000 -> done 44 cycles after start, digit = 3, max_score = 0x00050000.
REQ-030 All weights and biases 0 -> tie across all ten neurons -> digit = 0, max_score = 0.
REQ-031 w2_7 = 0x00010000 at every row 0..32, others 0, h_data = 0x00010000 -> max_score = 0x00210000 (33.0), digit = 7.
REQ-032 Biases only, w2_k = -(10-k) * 0x00010000 -> all scores negative -> digit = 9, max_score = 0xFFFF0000.
REQ-033 start held high continuously -> runs back-to-back; done every 45 cycles; busy low only during IDLE-accept cycles; start pulses during busy are ignored.
REQ-034 resetn low at cycle 20 of a run -> all outputs 0 immediately, no done pulse; restart after reset -> correct result per REQ-029.

Source files
------------

// File: rtl/layer2_classifier.sv
// Output layer of a fixed-point MLP: streams N_HID hidden activations plus a
// bias row through ten MAC accumulators, then scans them for the winning digit.
module layer2_classifier #(
    parameter int N_HID = 32,
    parameter int FRAC  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [31:0] ctr2,
    input  logic [31:0] w2_0,
    input  logic [31:0] w2_1,
    input  logic [31:0] w2_2,
    input  logic [31:0] w2_3,
    input  logic [31:0] w2_4,
    input  logic [31:0] w2_5,
    input  logic [31:0] w2_6,
    input  logic [31:0] w2_7,
    input  logic [31:0] w2_8,
    input  logic [31:0] w2_9,
    output logic [4:0]  h_addr,
    input  logic [31:0] h_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic [31:0] max_score
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ARGMAX} state_t;

    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC;

    state_t             r_state, w_next;
    logic [31:0]        r_ctr2;
    logic [31:0]        r_idx_p1;
    logic               r_vld_p1;
    logic signed [31:0] r_acc [10];
    logic [3:0]         r_scan;
    logic signed [31:0] r_best;
    logic [3:0]         r_bidx;
    logic               r_busy, r_done;
    logic [3:0]         r_digit;
    logic signed [31:0] r_max;

    logic signed [31:0] w_w2 [10];
    logic signed [31:0] w_act;
    logic signed [31:0] w_cand;
    logic               w_better;
    logic               w_accept, w_fetch, w_fetch_end, w_drain_end, w_argmax, w_scan_end;

    // Drop FRAC fraction bits of the full product and wrap to 32 bits.
    function automatic logic signed [31:0] frac_align(input logic signed [63:0] p);
        return p[FRAC +: 32];
    endfunction

    assign w_w2[0] = w2_0;
    assign w_w2[1] = w2_1;
    assign w_w2[2] = w2_2;
    assign w_w2[3] = w2_3;
    assign w_w2[4] = w2_4;
    assign w_w2[5] = w2_5;
    assign w_w2[6] = w2_6;
    assign w_w2[7] = w2_7;
    assign w_w2[8] = w2_8;
    assign w_w2[9] = w2_9;

    assign w_act    = (r_idx_p1 == 32'(N_HID)) ? ONE : h_data;
    assign w_cand   = r_acc[r_scan];
    assign w_better = (w_cand > r_best);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)       w_next = FETCH;
            FETCH:   if (w_fetch_end) w_next = DRAIN;
            DRAIN:   if (w_drain_end) w_next = ARGMAX;
            ARGMAX:  if (w_scan_end)  w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_accept    = (r_state == IDLE) && start;
        w_fetch     = (r_state == FETCH);
        w_fetch_end = w_fetch && (r_ctr2 == 32'(N_HID));
        w_drain_end = (r_state == DRAIN) && r_vld_p1 && (r_idx_p1 == 32'(N_HID));
        w_argmax    = (r_state == ARGMAX);
        w_scan_end  = w_argmax && (r_scan == 4'd9);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctr2   <= '0;
            r_idx_p1 <= '0;
            r_vld_p1 <= 1'b0;
            for (int j = 0; j < 10; j++) r_acc[j] <= '0;
            r_scan   <= '0;
            r_best   <= '0;
            r_bidx   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_digit  <= '0;
            r_max    <= '0;
        end else begin
            r_done <= 1'b0;
            // Address stage: row index tracks the one-cycle memory latency.
            r_vld_p1 <= w_fetch;
            r_idx_p1 <= r_ctr2;
            if (w_fetch) r_ctr2 <= w_fetch_end ? '0 : r_ctr2 + 32'd1;

            if (w_accept) begin
                r_ctr2 <= '0;
                r_busy <= 1'b1;
                for (int j = 0; j < 10; j++) r_acc[j] <= '0;
            end else if (r_vld_p1) begin
                for (int j = 0; j < 10; j++)
                    r_acc[j] <= r_acc[j] + frac_align(w_w2[j] * w_act);
            end

            // Argmax stage: neuron 0 seeds the best, later ones must beat it strictly.
            r_scan <= w_argmax ? r_scan + 4'd1 : 4'd0;
            if (w_argmax) begin
                if (r_scan == 4'd0) begin
                    r_best <= r_acc[0];
                    r_bidx <= 4'd0;
                end else if (w_better) begin
                    r_best <= w_cand;
                    r_bidx <= r_scan;
                end
            end

            if (w_scan_end) begin
                r_digit <= w_better ? r_scan : r_bidx;
                r_max   <= w_better ? w_cand : r_best;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign ctr2      = r_ctr2;
    assign h_addr    = r_ctr2[4:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign digit     = r_digit;
    assign max_score = r_max;

endmodule
